// File: rtl/wt_dcache_inval_queue.sv
// Queued L1 write-through dcache invalidation unit: buffers bus invalidations (merging duplicates),
// serialises tag lookups on the dcache read port and issues per-way or whole-cache invalidations.
module wt_dcache_inval_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PLEN  = 56,
    parameter int unsigned OFF_W = 4,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned TAG_W = 44,
    parameter int unsigned WAYS  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // bus invalidation interface
    input  logic             mem_inv_req_i,
    input  logic             mem_inv_all_i,
    input  logic [PLEN-1:0]  mem_inv_paddr_i,
    output logic             mem_inv_ack_o,
    output logic             busy_o,
    // dcache read port (tag lookup)
    output logic             rd_req_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [IDX_W-1:0] rd_idx_o,
    output logic             rd_tag_only_o,
    input  logic             rd_ack_i,
    input  logic [WAYS-1:0]  rd_vld_bits_i,
    input  logic [WAYS-1:0]  rd_hit_oh_i,
    // miss unit invalidation port
    output logic             inv_vld_o,
    output logic             inv_all_o,
    output logic [IDX_W-1:0] inv_idx_o,
    output logic [WAYS-1:0]  inv_way_o,
    input  logic             inv_ack_i
);

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned IDX_LSB   = OFF_W;
    localparam int unsigned TAG_LSB   = OFF_W + IDX_W;
    localparam int unsigned ADDR_USED = OFF_W + IDX_W + TAG_W;

    typedef struct packed {
        logic             all;
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        EVAL     = 2'd2,
        WAIT_INV = 2'd3
    } state_e;

    entry_t             fifo_q [DEPTH];
    logic [DEPTH-1:0]   slot_vld_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    state_e             state_q;
    state_e             state_d;
    logic               inv_all_q;
    logic [IDX_W-1:0]   inv_idx_q;
    logic [WAYS-1:0]    inv_way_q;

    entry_t             in_entry;
    entry_t             head;
    logic               full;
    logic               empty;
    logic [DEPTH-1:0]   match;
    logic               merge;
    logic               push;
    logic               pop;
    logic               latch_idx;
    logic               latch_way;
    logic               latch_all;
    logic [WAYS-1:0]    hit_way;

    // Offset (and any address bits above the tag) never take part in the invalidation.
    logic [OFF_W-1:0] unused_offset;
    assign unused_offset = mem_inv_paddr_i[OFF_W-1:0];

    if (PLEN > ADDR_USED) begin : g_upper_addr
        logic [PLEN-ADDR_USED-1:0] unused_upper;
        assign unused_upper = mem_inv_paddr_i[PLEN-1:ADDR_USED];
    end

    // Incoming request; an invalidate-all carries no address.
    always_comb begin
        in_entry     = '0;
        in_entry.all = mem_inv_all_i;
        if (!mem_inv_all_i) begin
            in_entry.tag = mem_inv_paddr_i[TAG_LSB +: TAG_W];
            in_entry.idx = mem_inv_paddr_i[IDX_LSB +: IDX_W];
        end
    end

    assign head  = fifo_q[rd_ptr_q];
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

    // Duplicate detection; the head is excluded once its processing has begun.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slot_vld_q[i] && !((state_q != IDLE) && (PTR_W'(i) == rd_ptr_q))) begin
                if (in_entry.all) begin
                    match[i] = fifo_q[i].all;
                end else begin
                    match[i] = !fifo_q[i].all &&
                               (fifo_q[i].tag == in_entry.tag) &&
                               (fifo_q[i].idx == in_entry.idx);
                end
            end
        end
    end

    assign merge         = |match;
    assign mem_inv_ack_o = mem_inv_req_i & (merge | ~full);
    assign push          = mem_inv_req_i & ~merge & ~full;

    assign busy_o        = ~empty | (state_q != IDLE);
    assign rd_tag_only_o = 1'b1;
    assign hit_way       = rd_vld_bits_i & rd_hit_oh_i;

    // Pending-request FIFO with per-slot valid bits for merge lookup.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            slot_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q]     <= in_entry;
                slot_vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                slot_vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q             <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // State register and held invalidation payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            inv_all_q <= 1'b0;
            inv_idx_q <= '0;
            inv_way_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_all) begin
                inv_all_q <= 1'b1;
                inv_idx_q <= '0;
                inv_way_q <= '0;
            end
            if (latch_idx) begin
                inv_all_q <= 1'b0;
                inv_idx_q <= head.idx;
            end
            if (latch_way) begin
                inv_way_q <= hit_way;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        rd_req_o  = 1'b0;
        rd_tag_o  = '0;
        rd_idx_o  = '0;
        inv_vld_o = 1'b0;
        inv_all_o = 1'b0;
        inv_idx_o = '0;
        inv_way_o = '0;
        pop       = 1'b0;
        latch_idx = 1'b0;
        latch_way = 1'b0;
        latch_all = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (head.all) begin
                        inv_vld_o = 1'b1;
                        inv_all_o = 1'b1;
                        latch_all = 1'b1;
                        state_d   = WAIT_INV;
                    end else begin
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                rd_req_o = 1'b1;
                rd_tag_o = head.tag;
                rd_idx_o = head.idx;
                if (rd_ack_i) begin
                    latch_idx = 1'b1;
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                latch_way = 1'b1;
                if (hit_way == '0) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end else begin
                    inv_vld_o = 1'b1;
                    inv_idx_o = inv_idx_q;
                    inv_way_o = hit_way;
                    if (inv_ack_i) begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_INV;
                    end
                end
            end
            WAIT_INV: begin
                inv_vld_o = 1'b1;
                inv_all_o = inv_all_q;
                inv_idx_o = inv_idx_q;
                inv_way_o = inv_way_q;
                if (inv_ack_i) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
